// File: rtl/op_command_sequencer_if.sv
// Bundle of button, switch and ALU-side command signals for op_command_sequencer.
// The master side drives the raw inputs and the slave side (the sequencer) drives the issued command.
interface op_command_sequencer_if;
    logic       enter_btn;
    logic [2:0] sw_op;
    logic [1:0] sw_k;
    logic       clear_ovf;
    logic [2:0] OP;
    logic [1:0] K;
    logic       Perform;
    logic       busy;
    logic [2:0] fifo_count;
    logic       full;
    logic       overflow;

    modport master (
        output enter_btn, sw_op, sw_k, clear_ovf,
        input  OP, K, Perform, busy, fifo_count, full, overflow
    );

    modport slave (
        input  enter_btn, sw_op, sw_k, clear_ovf,
        output OP, K, Perform, busy, fifo_count, full, overflow
    );
endinterface

// File: rtl/op_command_sequencer.sv
// Debounced Enter capture of OP/K into a 4-deep command FIFO, issued to the ALU
// as a stable OP/K word framed by a registered Perform pulse.
module op_command_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETUP_CYCLES    = 1,
    parameter int PULSE_CYCLES    = 2,
    parameter int HOLD_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    op_command_sequencer_if.slave bus
);
    localparam int DW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SP_MAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int T_MAX  = (SP_MAX > HOLD_CYCLES) ? SP_MAX : HOLD_CYCLES;
    localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    FIFO_DEPTH = 3'd4;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    logic [1:0]    sync_reg;
    logic          btn_s;
    logic          deb_reg;
    logic [DW-1:0] deb_cnt_reg;
    logic          push_reg;

    logic [4:0]    fifo_mem [4];
    logic [1:0]    wr_ptr_reg;
    logic [1:0]    rd_ptr_reg;
    logic [2:0]    count_reg;
    logic          fifo_wr;
    logic          fifo_drop;
    logic          ovf_reg;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          pop;
    logic [2:0]    op_reg;
    logic [1:0]    k_reg;
    logic          perform_reg;

    assign btn_s = sync_reg[1];

    // The counter only runs while the synchronised level disagrees with deb;
    // the push strobe is raised on the edge that accepts a new high level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg    <= 2'b00;
            deb_reg     <= 1'b0;
            deb_cnt_reg <= '0;
            push_reg    <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], bus.enter_btn};
            push_reg <= 1'b0;
            if (btn_s == deb_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                deb_reg     <= btn_s;
                deb_cnt_reg <= '0;
                push_reg    <= btn_s;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign fifo_wr   = push_reg && ((count_reg != FIFO_DEPTH) || pop);
    assign fifo_drop = push_reg && (count_reg == FIFO_DEPTH) && !pop;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg] <= {bus.sw_op, bus.sw_k};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
            ovf_reg    <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= count_reg + 3'(fifo_wr) - 3'(pop);
            if (bus.clear_ovf) begin
                ovf_reg <= 1'b0;
            end else if (fifo_drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            op_reg      <= 3'd0;
            k_reg       <= 2'd0;
            perform_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            perform_reg <= (state_next == PULSE);
            if (pop) begin
                op_reg <= fifo_mem[rd_ptr_reg][4:2];
                k_reg  <= fifo_mem[rd_ptr_reg][1:0];
            end
        end
    end

    // Each timed state loads the shared timer with its length minus one on entry
    // and leaves when the timer has reached zero.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != 3'd0) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                    timer_next = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (timer_reg == '0) begin
                    state_next = PULSE;
                    timer_next = PULSE_LOAD;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            PULSE: begin
                if (timer_reg == '0) begin
                    state_next = HOLD;
                    timer_next = HOLD_LOAD;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            HOLD: begin
                if (timer_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.OP         = op_reg;
    assign bus.K          = k_reg;
    assign bus.Perform    = perform_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.fifo_count = count_reg;
    assign bus.full       = (count_reg == FIFO_DEPTH);
    assign bus.overflow   = ovf_reg;
endmodule

// File: tb/tb_op_command_sequencer.sv
// Drives two sequencers (default timing and a long-HOLD variant) with shared stimulus
// and compares every output each cycle against a queue/time-based reference model.
module tb_op_command_sequencer;
    localparam int DEB = 4;
    localparam int PS [2] = '{1, 1};
    localparam int PP [2] = '{2, 2};
    localparam int PH [2] = '{2, 50};

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic       clr;
    logic [2:0] swop;
    logic [1:0] swk;

    op_command_sequencer_if ifa ();
    op_command_sequencer_if ifb ();

    assign ifa.enter_btn = btn;
    assign ifa.sw_op     = swop;
    assign ifa.sw_k      = swk;
    assign ifa.clear_ovf = clr;
    assign ifb.enter_btn = btn;
    assign ifb.sw_op     = swop;
    assign ifb.sw_k      = swk;
    assign ifb.clear_ovf = clr;

    op_command_sequencer #(
        .DEBOUNCE_CYCLES(DEB), .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(2)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );

    op_command_sequencer #(
        .DEBOUNCE_CYCLES(DEB), .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(50)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: btn delay line, run-length debounce, array queue, and
    // issue timing measured as edges elapsed since the pop.
    logic       m_s1, m_s2, m_deb, m_last, m_push;
    int         m_len;
    logic [4:0] m_q [2][4];
    int         m_n [2];
    logic       m_iss [2];
    int         m_el [2];
    logic [2:0] m_op [2];
    logic [1:0] m_k [2];
    logic       m_ovf [2];

    function automatic logic m_perf(int i);
        return m_iss[i] && (m_el[i] >= PS[i]) && (m_el[i] < PS[i] + PP[i]);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic timeout(string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=event t=%0t", tag, $time);
    endtask

    task automatic model_edge();
        logic b;
        logic np;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_last = 0; m_len = 0; m_push = 0;
            for (int i = 0; i < 2; i++) begin
                m_n[i] = 0; m_iss[i] = 0; m_el[i] = 0;
                m_op[i] = 0; m_k[i] = 0; m_ovf[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            automatic logic pop  = !m_iss[i] && (m_n[i] > 0);
            automatic logic drop = 1'b0;
            if (m_iss[i]) begin
                m_el[i]++;
                if (m_el[i] == PS[i] + PP[i] + PH[i]) m_iss[i] = 0;
            end
            if (pop) begin
                m_op[i] = m_q[i][0][4:2];
                m_k[i]  = m_q[i][0][1:0];
                for (int j = 0; j < 3; j++) m_q[i][j] = m_q[i][j + 1];
                m_n[i]--;
                m_iss[i] = 1;
                m_el[i]  = 0;
                $display("issue dut%0d op=%b k=%b t=%0t", i, m_op[i], m_k[i], $time);
            end
            if (m_push) begin
                if (m_n[i] < 4) begin
                    m_q[i][m_n[i]] = {swop, swk};
                    m_n[i]++;
                end else begin
                    drop = 1'b1;
                end
            end
            if (clr) m_ovf[i] = 0;
            else if (drop) m_ovf[i] = 1;
        end
        b  = m_s2;
        np = 1'b0;
        if (b == m_last) m_len++;
        else m_len = 1;
        m_last = b;
        if ((b != m_deb) && (m_len >= DEB)) begin
            m_deb = b;
            np    = b;
        end
        m_push = np;
        m_s2   = m_s1;
        m_s1   = btn;
    endtask

    task automatic check_all();
        chk("A.OP", 32'(ifa.OP), 32'(m_op[0]));
        chk("A.K", 32'(ifa.K), 32'(m_k[0]));
        chk("A.Perform", 32'(ifa.Perform), 32'(m_perf(0)));
        chk("A.busy", 32'(ifa.busy), 32'(m_iss[0]));
        chk("A.fifo_count", 32'(ifa.fifo_count), 32'(m_n[0]));
        chk("A.full", 32'(ifa.full), 32'(m_n[0] == 4));
        chk("A.overflow", 32'(ifa.overflow), 32'(m_ovf[0]));
        chk("B.OP", 32'(ifb.OP), 32'(m_op[1]));
        chk("B.K", 32'(ifb.K), 32'(m_k[1]));
        chk("B.Perform", 32'(ifb.Perform), 32'(m_perf(1)));
        chk("B.busy", 32'(ifb.busy), 32'(m_iss[1]));
        chk("B.fifo_count", 32'(ifb.fifo_count), 32'(m_n[1]));
        chk("B.full", 32'(ifb.full), 32'(m_n[1] == 4));
        chk("B.overflow", 32'(ifb.overflow), 32'(m_ovf[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_idle(string tag);
        int guard = 0;
        while (!(m_iss[0] == 0 && m_n[0] == 0 && m_iss[1] == 0 && m_n[1] == 0)) begin
            if (guard++ > 2000) begin
                timeout(tag);
                return;
            end
            tick();
        end
    endtask

    logic [4:0] cap [7];
    logic [2:0] r_cnt [15];
    logic [2:0] r_op [15];
    logic [1:0] r_k [15];
    logic       r_perf [15];
    logic       r_busy [15];

    initial begin
        int  rises;
        int  guard;
        int  perf_seen;
        logic prev_busy;
        logic [11:0] bounce;

        reset = 1; btn = 1; clr = 0; swop = 3'b011; swk = 2'b10;
        repeat (3) tick();
        chk("reset.OP", 32'(ifa.OP), 32'd0);
        chk("reset.fifo_count", 32'(ifb.fifo_count), 32'd0);

        // Button held through reset: exactly one push, none on release.
        reset = 0;
        rises = 0; prev_busy = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 14) btn = 0;
            tick();
            if (ifa.busy && !prev_busy) rises++;
            prev_busy = ifa.busy;
        end
        chk("held_reset.pushes", 32'(rises), 32'd1);
        wait_idle("idle_after_reset");

        // Clean press with relative edge numbering (edge 1 is the first to sample the button).
        swop = 3'b100; swk = 2'b01; btn = 1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            r_cnt[e] = ifa.fifo_count; r_op[e] = ifa.OP; r_k[e] = ifa.K;
            r_perf[e] = ifa.Perform; r_busy[e] = ifa.busy;
        end
        chk("clean.count_e6", 32'(r_cnt[6]), 32'd0);
        chk("clean.count_e7", 32'(r_cnt[7]), 32'd1);
        chk("clean.op_e8", 32'(r_op[8]), 32'd4);
        chk("clean.k_e8", 32'(r_k[8]), 32'd1);
        chk("clean.perf_e8", 32'(r_perf[8]), 32'd0);
        chk("clean.perf_e9", 32'(r_perf[9]), 32'd1);
        chk("clean.perf_e10", 32'(r_perf[10]), 32'd1);
        chk("clean.perf_e11", 32'(r_perf[11]), 32'd0);
        chk("clean.busy_e12", 32'(r_busy[12]), 32'd1);
        chk("clean.busy_e13", 32'(r_busy[13]), 32'd0);
        btn = 0;
        wait_idle("idle_after_clean");
        repeat (8) tick();

        // Bouncy press: high 2, low 1, then stable high.
        bounce = 12'b111111111011;
        swop = 3'b010; swk = 2'b11;
        rises = 0; prev_busy = 0;
        for (int c = 0; c < 40; c++) begin
            btn = (c < 12) ? bounce[c] : 1'b0;
            tick();
            if (ifa.busy && !prev_busy) rises++;
            prev_busy = ifa.busy;
        end
        chk("bounce.pushes", 32'(rises), 32'd1);
        wait_idle("idle_after_bounce");
        repeat (8) tick();

        // Six quick presses against the long-HOLD instance: the sixth is dropped.
        for (int p = 0; p < 6; p++) begin
            swop = 3'($urandom); swk = 2'($urandom);
            cap[p] = {swop, swk};
            btn = 1; repeat (5) tick();
            btn = 0; repeat (5) tick();
        end
        chk("six.B.fifo_count", 32'(ifb.fifo_count), 32'd4);
        chk("six.B.full", 32'(ifb.full), 32'd1);
        chk("six.B.overflow", 32'(ifb.overflow), 32'd1);
        chk("six.B.first_issue", 32'({ifb.OP, ifb.K}), 32'(cap[0]));
        clr = 1; tick(); clr = 0;
        chk("clear.B.overflow", 32'(ifb.overflow), 32'd0);

        // Refill to four, then time a press so its push meets the IDLE pop.
        swop = 3'($urandom); swk = 2'($urandom); cap[6] = {swop, swk};
        btn = 1; repeat (5) tick(); btn = 0;
        guard = 0;
        while (!(m_iss[1] && m_el[1] == PS[1] + PP[1] + PH[1] - 6 && m_n[1] == 4 &&
                 !m_deb && !m_s1 && !m_s2)) begin
            if (guard++ > 400) break;
            tick();
        end
        if (guard > 400) begin
            timeout("coincide.wait");
        end else begin
            chk("coincide.B.second_issue", 32'({ifb.OP, ifb.K}), 32'(cap[1]));
            swop = 3'($urandom); swk = 2'($urandom);
            btn = 1; repeat (7) tick();
            chk("coincide.B.fifo_count", 32'(ifb.fifo_count), 32'd4);
            chk("coincide.B.overflow", 32'(ifb.overflow), 32'd0);
            chk("coincide.B.busy", 32'(ifb.busy), 32'd1);
            chk("coincide.B.third_issue", 32'({ifb.OP, ifb.K}), 32'(cap[2]));
            btn = 0; repeat (6) tick();
        end
        clr = 1; tick(); clr = 0;
        chk("clear2.B.overflow", 32'(ifb.overflow), 32'd0);

        // Reset while the default instance is in PULSE.
        guard = 0;
        while (!(m_iss[0] == 0 && m_n[0] == 0) && guard++ < 200) tick();
        swop = 3'b111; swk = 2'b11;
        btn = 1; repeat (5) tick(); btn = 0;
        guard = 0;
        while (!m_perf(0) && guard++ < 50) tick();
        if (!m_perf(0)) timeout("pulse.wait");
        reset = 1; tick(); reset = 0;
        chk("pulse_reset.Perform", 32'(ifa.Perform), 32'd0);
        chk("pulse_reset.OP", 32'(ifa.OP), 32'd0);
        chk("pulse_reset.fifo_count", 32'(ifa.fifo_count), 32'd0);
        perf_seen = 0;
        repeat (30) begin
            tick();
            if (ifa.Perform !== 1'b0) perf_seen++;
        end
        chk("pulse_reset.no_perform", 32'(perf_seen), 32'd0);

        // Random presses with bounce, switch churn and occasional overflow clears.
        for (int p = 0; p < 40; p++) begin
            int nb;
            int hi;
            int lo;
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) begin
                btn = 1;
                repeat ($urandom_range(1, 3)) begin
                    clr = ($urandom_range(0, 15) == 0);
                    swop = 3'($urandom); swk = 2'($urandom);
                    tick();
                end
                btn = 0;
                repeat ($urandom_range(1, 3)) begin
                    clr = ($urandom_range(0, 15) == 0);
                    tick();
                end
            end
            hi = $urandom_range(4, 15);
            lo = $urandom_range(4, 25);
            btn = 1;
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) btn = 0;
                clr = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    swop = 3'($urandom); swk = 2'($urandom);
                end
                tick();
            end
        end
        clr = 0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
